vec_unit_scheduler: RTL and testbench

- Shares one fully pipelined, fixed-latency vector unit among NREQ requesters. The unit is the normalize datapath: 3×27-bit in, 3×27-bit out, no stall input.
- Round-robin arbitration, at most one issue per cycle.
- Tags each issue, then routes the result back to its owner LATENCY cycles later.
- Per-requester credit limit bounds the responses owed to each client.

---
 rtl/vec_sched_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/vec_unit_scheduler.sv | 155 +++++++++++++++
 tb/tb_vec_unit_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_sched_pkg.sv
// Shared constants and helpers for the vector-unit scheduler family.
package vec_sched_pkg;

  localparam int W = 27;
  localparam logic [W-1:0] FP_ONE  = 27'h1FC0000;
  localparam logic [W-1:0] FP_ZERO = '0;

  // Width of an owner index; a one-requester index still needs one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after ptr_i, wrapping modulo NREQ.
module rr_arbiter
  import vec_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = tag_w(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand;

  // Scan offsets from far to near so the requester closest to ptr wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr_i) + i) % NREQ);
      if (valid_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_unit_scheduler.sv
// Shares one fixed-latency vector unit among NREQ requesters with round-robin
// issue, an owner tag pipeline for result routing, and per-requester credits.
module vec_unit_scheduler
  import vec_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = vec_sched_pkg::W,
  parameter int LATENCY = 9,
  parameter int MAX_OUT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*W-1:0] i_req_x,
  input  logic [NREQ*W-1:0] i_req_y,
  input  logic [NREQ*W-1:0] i_req_z,
  output logic              o_unit_valid,
  output logic [W-1:0]      o_unit_x,
  output logic [W-1:0]      o_unit_y,
  output logic [W-1:0]      o_unit_z,
  input  logic [W-1:0]      i_unit_x,
  input  logic [W-1:0]      i_unit_y,
  input  logic [W-1:0]      i_unit_z,
  output logic [NREQ-1:0]   o_rsp_valid,
  output logic [W-1:0]      o_rsp_x,
  output logic [W-1:0]      o_rsp_y,
  output logic [W-1:0]      o_rsp_z,
  output logic              o_busy
);

  localparam int IW = tag_w(NREQ);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic            unit_valid_q;
  logic [W-1:0]    unit_x_q, unit_y_q, unit_z_q;
  logic [IW-1:0]   unit_own_q;

  logic [LATENCY-1:0]         tag_v_q;
  logic [LATENCY-1:0][IW-1:0] tag_own_q;

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_x_q, rsp_y_q, rsp_z_q;
  logic [NREQ-1:0] cnt_nz;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .valid_i (eligible),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // Credit counter per requester: up on accept, down on its response strobe.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [CW-1:0] cnt_q, cnt_d;

    assign eligible[gi] = i_req_valid[gi] && (cnt_q < CW'(MAX_OUT));
    assign cnt_nz[gi]   = |cnt_q;

    always_comb begin
      cnt_d = cnt_q;
      if (grant[gi] && !rsp_valid_q[gi]) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!grant[gi] && rsp_valid_q[gi]) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(rsp_valid_q[gi] && (cnt_q == '0)));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    if (tag_v_q[LATENCY-1]) begin
      rsp_valid_d = NREQ'(1) << tag_own_q[LATENCY-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q        <= '0;
      unit_valid_q <= 1'b0;
      unit_x_q     <= FP_ZERO;
      unit_y_q     <= FP_ZERO;
      unit_z_q     <= FP_ZERO;
      unit_own_q   <= '0;
      tag_v_q      <= '0;
      tag_own_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_x_q      <= FP_ZERO;
      rsp_y_q      <= FP_ZERO;
      rsp_z_q      <= FP_ZERO;
    end else begin
      ptr_q        <= ptr_d;
      unit_valid_q <= grant_any;
      if (grant_any) begin
        unit_x_q   <= i_req_x[grant_idx*W +: W];
        unit_y_q   <= i_req_y[grant_idx*W +: W];
        unit_z_q   <= i_req_z[grant_idx*W +: W];
        unit_own_q <= grant_idx;
      end
      // Stage LATENCY-1 lines up with the unit's result for the same issue.
      tag_v_q[0]   <= unit_valid_q;
      tag_own_q[0] <= unit_own_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
      rsp_valid_q <= rsp_valid_d;
      if (tag_v_q[LATENCY-1]) begin
        rsp_x_q <= i_unit_x;
        rsp_y_q <= i_unit_y;
        rsp_z_q <= i_unit_z;
      end
    end
  end

  assign o_req_ready  = grant;
  assign o_unit_valid = unit_valid_q;
  assign o_unit_x     = unit_x_q;
  assign o_unit_y     = unit_y_q;
  assign o_unit_z     = unit_z_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_x      = rsp_x_q;
  assign o_rsp_y      = rsp_y_q;
  assign o_rsp_z      = rsp_z_q;
  assign o_busy       = (|tag_v_q) || unit_valid_q || (|cnt_nz);

endmodule

// File: tb/tb_vec_unit_scheduler.sv
// Directed bench for vec_unit_scheduler; the vector unit is modelled as a pure delay line.
module tb_vec_unit_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 27;
  localparam int LAT  = 9;
  localparam int MAXO = 4;
  localparam logic [W-1:0] ONE = 27'h1FC0000;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [NREQ-1:0]   i_req_valid = '0;
  logic [NREQ-1:0]   o_req_ready;
  logic [NREQ*W-1:0] i_req_x = '0, i_req_y = '0, i_req_z = '0;
  logic              o_unit_valid;
  logic [W-1:0]      o_unit_x, o_unit_y, o_unit_z;
  logic [W-1:0]      i_unit_x, i_unit_y, i_unit_z;
  logic [NREQ-1:0]   o_rsp_valid;
  logic [W-1:0]      o_rsp_x, o_rsp_y, o_rsp_z;
  logic              o_busy;

  logic [W-1:0] dx [LAT];
  logic [W-1:0] dy [LAT];
  logic [W-1:0] dz [LAT];

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    dx[0] <= o_unit_x;
    dy[0] <= o_unit_y;
    dz[0] <= o_unit_z;
    for (int i = 1; i < LAT; i++) begin
      dx[i] <= dx[i-1];
      dy[i] <= dy[i-1];
      dz[i] <= dz[i-1];
    end
  end
  assign i_unit_x = dx[LAT-1];
  assign i_unit_y = dy[LAT-1];
  assign i_unit_z = dz[LAT-1];

  vec_unit_scheduler #(
    .NREQ(NREQ), .W(W), .LATENCY(LAT), .MAX_OUT(MAXO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_x(i_req_x), .i_req_y(i_req_y), .i_req_z(i_req_z),
    .o_unit_valid(o_unit_valid),
    .o_unit_x(o_unit_x), .o_unit_y(o_unit_y), .o_unit_z(o_unit_z),
    .i_unit_x(i_unit_x), .i_unit_y(i_unit_y), .i_unit_z(i_unit_z),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_x(o_rsp_x), .o_rsp_y(o_rsp_y), .o_rsp_z(o_rsp_z),
    .o_busy(o_busy)
  );

  // Each cycle: drive at the falling edge, sample 1 time unit later.
  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_req_valid = '0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_req_valid = '0;
    #1;
    n_cmp++; if (o_unit_valid !== 1'b0) begin n_err++; $display("FAIL reset_unit_valid got=%b exp=0", o_unit_valid); end
    n_cmp++; if (o_rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0000", o_rsp_valid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    n_cmp++; if ({o_unit_x, o_rsp_x} !== '0) begin n_err++; $display("FAIL reset_data unit_x=%h rsp_x=%h exp=0", o_unit_x, o_rsp_x); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_req_valid = 4'b1111;
    #1;
    n_cmp++; if (o_req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_ptr_grant got=%b exp=0001", o_req_ready); end
    i_req_valid = '0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [NREQ-1:0] ev;
    do_reset();
    i_req_valid = 4'b0010;
    i_req_x[1*W +: W] = ONE;
    i_req_y[1*W +: W] = '0;
    i_req_z[1*W +: W] = '0;
    #1;
    n_cmp++; if (o_req_ready !== 4'b0010) begin n_err++; $display("FAIL single_ready got=%b exp=0010", o_req_ready); end
    for (int c = 1; c <= 12; c++) begin
      @(negedge i_clk);
      i_req_valid = '0;
      #1;
      ev = (c == 11) ? 4'b0010 : 4'b0000;
      n_cmp++; if (o_rsp_valid !== ev) begin n_err++; $display("FAIL single_rsp_valid c=%0d got=%b exp=%b", c, o_rsp_valid, ev); end
      if (c == 11) begin
        n_cmp++; if (o_rsp_x !== ONE) begin n_err++; $display("FAIL single_rsp_x got=%h exp=%h", o_rsp_x, ONE); end
      end
      n_cmp++; if (o_busy !== (c <= 11)) begin n_err++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, o_busy, (c <= 11)); end
    end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] ev;
    logic [W-1:0]    ex;
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      i_req_x[r*W +: W] = W'(r);
      i_req_y[r*W +: W] = W'(r + 16);
      i_req_z[r*W +: W] = W'(r + 32);
    end
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge i_clk);
      i_req_valid = (c < 12) ? 4'b1111 : 4'b0000;
      #1;
      ev = (c < 12) ? (4'b0001 << (c % 4)) : 4'b0000;
      n_cmp++; if (o_req_ready !== ev) begin n_err++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, o_req_ready, ev); end
      ev = (c >= 11 && c < 23) ? (4'b0001 << ((c - 11) % 4)) : 4'b0000;
      n_cmp++; if (o_rsp_valid !== ev) begin n_err++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, o_rsp_valid, ev); end
      if (c >= 11 && c < 23) begin
        ex = W'((c - 11) % 4);
        n_cmp++; if (o_rsp_x !== ex || o_rsp_y !== ex + 16 || o_rsp_z !== ex + 32) begin
          n_err++; $display("FAIL rr_rsp_data c=%0d got=%h/%h/%h exp=%h/%h/%h", c, o_rsp_x, o_rsp_y, o_rsp_z, ex, ex + 16, ex + 32);
        end
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_credit_limit();
    logic [NREQ-1:0] ev;
    logic [W-1:0]    q[$];
    logic [W-1:0]    ex;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge i_clk);
      i_req_valid = (c < 36) ? 4'b0100 : 4'b0000;
      i_req_x[2*W +: W] = W'(c);
      #1;
      ev = (c < 36 && (c % 12) < 4) ? 4'b0100 : 4'b0000;
      n_cmp++; if (o_req_ready !== ev) begin n_err++; $display("FAIL credit_ready c=%0d got=%b exp=%b", c, o_req_ready, ev); end
      ev = (c >= 11 && ((c - 11) % 12) < 4) ? 4'b0100 : 4'b0000;
      n_cmp++; if (o_rsp_valid !== ev) begin n_err++; $display("FAIL credit_rsp_valid c=%0d got=%b exp=%b", c, o_rsp_valid, ev); end
      if (ev != 0 && q.size() > 0) begin
        ex = q.pop_front();
        n_cmp++; if (o_rsp_x !== ex) begin n_err++; $display("FAIL credit_rsp_order c=%0d got=%h exp=%h", c, o_rsp_x, ex); end
      end
      if (c < 36 && (c % 12) < 4) q.push_back(W'(c));
    end
    $display("test_credit_limit done");
  endtask

  task automatic test_simultaneous();
    logic [NREQ-1:0] ev;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      if (c > 0) @(negedge i_clk);
      i_req_valid = (c < 3 || c >= 11) ? 4'b0001 : 4'b0000;
      i_req_x[0 +: W] = W'(c);
      #1;
      ev = (c < 3 || (c >= 11 && c <= 14)) ? 4'b0001 : 4'b0000;
      n_cmp++; if (o_req_ready !== ev) begin n_err++; $display("FAIL simul_ready c=%0d got=%b exp=%b", c, o_req_ready, ev); end
      ev = (c >= 11 && c <= 13) ? 4'b0001 : 4'b0000;
      n_cmp++; if (o_rsp_valid !== ev) begin n_err++; $display("FAIL simul_rsp_valid c=%0d got=%b exp=%b", c, o_rsp_valid, ev); end
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_midflight();
    logic [NREQ-1:0] ev;
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      i_req_x[r*W +: W] = W'(r + 1);
      i_req_y[r*W +: W] = W'(r + 1);
      i_req_z[r*W +: W] = W'(r + 1);
    end
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge i_clk);
      i_req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
    end
    n_cmp++; if (o_rsp_valid !== 4'b0010 || o_rsp_x !== 27'd2 || o_busy !== 1'b1) begin
      n_err++; $display("FAIL midflight_pre rsp_valid=%b rsp_x=%h busy=%b exp=0010/2/1", o_rsp_valid, o_rsp_x, o_busy);
    end
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if ({o_unit_valid, o_rsp_valid, o_busy} !== '0 || {o_unit_x, o_rsp_x, o_rsp_y} !== '0) begin
      n_err++; $display("FAIL midflight_reset uv=%b rv=%b busy=%b ux=%h rx=%h exp=all0", o_unit_valid, o_rsp_valid, o_busy, o_unit_x, o_rsp_x);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge i_clk);
      #1;
      n_cmp++; if (o_rsp_valid !== 4'b0000 || o_busy !== 1'b0) begin
        n_err++; $display("FAIL midflight_stale c=%0d rsp_valid=%b busy=%b exp=0000/0", c, o_rsp_valid, o_busy);
      end
    end
    i_req_x[2*W +: W] = ONE;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      i_req_valid = (c == 0) ? 4'b0100 : 4'b0000;
      #1;
      if (c == 0) begin
        n_cmp++; if (o_req_ready !== 4'b0100) begin n_err++; $display("FAIL midflight_new_ready got=%b exp=0100", o_req_ready); end
      end
      ev = (c == 11) ? 4'b0100 : 4'b0000;
      n_cmp++; if (o_rsp_valid !== ev) begin n_err++; $display("FAIL midflight_new_rsp c=%0d got=%b exp=%b", c, o_rsp_valid, ev); end
      if (c == 11) begin
        n_cmp++; if (o_rsp_x !== ONE) begin n_err++; $display("FAIL midflight_new_x got=%h exp=%h", o_rsp_x, ONE); end
      end
    end
    $display("test_reset_midflight done");
  endtask

  task automatic test_idle();
    logic [NREQ-1:0] ev;
    do_reset();
    i_req_valid = 4'b0010;
    #1;
    n_cmp++; if (o_req_ready !== 4'b0010) begin n_err++; $display("FAIL idle_first_ready got=%b exp=0010", o_req_ready); end
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      i_req_valid = '0;
      #1;
      n_cmp++; if (o_unit_valid !== (c == 1)) begin n_err++; $display("FAIL idle_unit_valid c=%0d got=%b exp=%b", c, o_unit_valid, (c == 1)); end
      ev = (c == 11) ? 4'b0010 : 4'b0000;
      n_cmp++; if (o_rsp_valid !== ev) begin n_err++; $display("FAIL idle_rsp_valid c=%0d got=%b exp=%b", c, o_rsp_valid, ev); end
    end
    @(negedge i_clk);
    i_req_valid = 4'b1111;
    #1;
    n_cmp++; if (o_req_ready !== 4'b0100) begin n_err++; $display("FAIL idle_ptr_hold got=%b exp=0100", o_req_ready); end
    i_req_valid = '0;
    $display("test_idle done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credit_limit();
    test_simultaneous();
    test_reset_midflight();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
